// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB encodings and bridge state enum.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_e;

    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_apb_decode.sv
// Combinational APB window decode: hit flag and one-hot slave select.
module ahb_apb_decode
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                NSLV        = 3,
    parameter logic [ADDR_W-1:0] BASE        = ADDR_W'(32'h8000_0000),
    parameter int                REGION_BITS = 12
) (
    input  logic [ADDR_W-1:0] haddr_i,
    output logic              hit_o,
    output logic [NSLV-1:0]   sel_o
);

    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] idx;

    // Unsigned offset; the lower bound check guards against the wrapped subtraction.
    assign off   = haddr_i - BASE;
    assign idx   = off >> REGION_BITS;
    assign hit_o = (haddr_i >= BASE) && (idx < ADDR_W'(NSLV));

    for (genvar i = 0; i < NSLV; i++) begin : g_sel
        assign sel_o[i] = hit_o && (idx == ADDR_W'(i));
    end

endmodule

// File: rtl/ahb_apb_bridge_p.sv
// AHB-to-APB bridge. Define APB_TIMEOUT_EN to add an ACCESS-phase watchdog
// that errors out after TIMEOUT_CYC stalled cycles.
module ahb_apb_bridge_p
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NSLV        = 3,
    parameter logic [ADDR_W-1:0] BASE        = ADDR_W'(32'h8000_0000),
    parameter int                REGION_BITS = 12,
    parameter int                TIMEOUT_CYC = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HWRITE,
    input  logic [1:0]        HTRANS,
    input  logic              HREADYin,
    output logic              HREADYout,
    output logic [DATA_W-1:0] HRDATA,
    output logic [1:0]        HRESP,
    output logic [NSLV-1:0]   PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    if (NSLV < 1 || NSLV > 16 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("ahb_apb_bridge_p: NSLV must be 1..16 and TIMEOUT_CYC >= 1");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [NSLV-1:0]   sel_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              dec_hit;
    logic [NSLV-1:0]   dec_sel;
    logic              accept;
    logic              tmo_hit;

    ahb_apb_decode #(
        .ADDR_W      (ADDR_W),
        .NSLV        (NSLV),
        .BASE        (BASE),
        .REGION_BITS (REGION_BITS)
    ) u_decode (
        .haddr_i (HADDR),
        .hit_o   (dec_hit),
        .sel_o   (dec_sel)
    );

    assign accept = HREADYin && HREADYout && trans_active(HTRANS);

`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q;

    always_ff @(posedge HCLK) begin
        if (!HRESETn || state_q != ST_ACCESS) tmo_q <= '0;
        else if (!PREADY)                     tmo_q <= tmo_q + TW'(1);
    end

    // Fires on the TIMEOUT_CYC-th stalled ACCESS cycle.
    assign tmo_hit = !PREADY && (tmo_q == TW'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (!HRESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (!accept)      state_d = ST_IDLE;
                else if (!dec_hit) state_d = ST_ERR1;
                else if (HWRITE)   state_d = ST_WDATA;
                else               state_d = ST_SETUP;
            end
            ST_WDATA:  state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY)       state_d = PSLVERR ? ST_ERR1 : ST_DONE;
                else if (tmo_hit) state_d = ST_ERR1;
            end
            ST_ERR1:   state_d = ST_ERR2;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        HREADYout = 1'b0;
        HRESP     = HRESP_OKAY;
        PSEL      = '0;
        PENABLE   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: HREADYout = 1'b1;
            ST_SETUP:         PSEL      = sel_q;
            ST_ACCESS: begin
                PSEL    = sel_q;
                PENABLE = 1'b1;
            end
            ST_ERR1:          HRESP     = HRESP_ERROR;
            ST_ERR2: begin
                HRESP     = HRESP_ERROR;
                HREADYout = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= HADDR;
                write_q <= HWRITE;
                sel_q   <= dec_sel;
            end
            // AHB write data arrives one cycle after the address phase.
            if (state_q == ST_WDATA) wdata_q <= HWDATA;
            if (state_q == ST_ACCESS && PREADY && !write_q) rdata_q <= PRDATA;
        end
    end

    assign PADDR  = addr_q;
    assign PWRITE = write_q;
    assign PWDATA = wdata_q;
    assign HRDATA = rdata_q;

endmodule

// File: doc/ahb_apb_bridge_p.md
AHB_APB_BRIDGE_P -- requirements
Module: ahb_apb_bridge_p

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width of HADDR and PADDR.
REQ-002 SHALL have parameter DATA_W, default 32: width of HWDATA, HRDATA, PWDATA and PRDATA.
REQ-003 SHALL have parameter NSLV, default 3, range 1..16: number of APB slaves; this is also the width of PSEL.
REQ-004 SHALL have parameter BASE, default 32'h8000_0000: base address of the APB window.
REQ-005 SHALL have parameter REGION_BITS, default 12: each slave decodes 2^REGION_BITS bytes.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 16: ACCESS watchdog limit, used only when APB_TIMEOUT_EN is defined.
REQ-007 SHALL have ports as follows (name, direction, width, meaning):
- HCLK  in  1  single clock; all logic on the rising edge.
- HRESETn  in  1  synchronous, active-low reset.
- HADDR  in  ADDR_W  AHB address.
- HWDATA  in  DATA_W  AHB write data.
- HWRITE  in  1  1 = write.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HREADYin  in  1  bus ready.
- HREADYout  out  1  bridge ready.
- HRDATA  out  DATA_W  read data.
- HRESP  out  2  OKAY=00, ERROR=01.
- PSEL  out  NSLV  one-hot slave select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Function
REQ-008 SHALL accept a transfer on a rising edge when HREADYin=1, HREADYout=1 and HTRANS is NONSEQ or SEQ; on acceptance it registers HADDR and HWRITE.
REQ-009 SHALL, for IDLE or BUSY transfers, give a zero-wait OKAY response and generate no APB activity.
REQ-010 SHALL decode a hit when BASE <= HADDR < BASE + (NSLV << REGION_BITS); the selected slave index is (HADDR - BASE) >> REGION_BITS.
REQ-011 SHALL implement the states IDLE, WDATA, SETUP, ACCESS, DONE, ERR1 and ERR2.
REQ-012 SHALL make these transitions on an accepted transfer:
- decode miss -> ERR1;
- hit read -> SETUP;
- hit write -> WDATA, capturing HWDATA at the end of WDATA, then -> SETUP.
REQ-013 SHALL, in SETUP, drive PSEL[index]=1 and PENABLE=0 with PADDR, PWRITE and PWDATA valid, then move to ACCESS unconditionally.
REQ-014 SHALL, in ACCESS, drive PENABLE=1 and hold all APB outputs stable until PREADY=1.
REQ-015 SHALL, when PREADY=1 in ACCESS, go to ERR1 if PSLVERR=1 and to DONE otherwise; PSEL and PENABLE drop on the next edge.
REQ-016 SHALL, in DONE, drive HREADYout=1 and HRESP=OKAY; for reads, HRDATA holds the PRDATA registered at the PREADY edge.
REQ-017 SHALL, in ERR1, drive HRESP=ERROR with HREADYout=0; in ERR2, drive HRESP=ERROR with HREADYout=1, then behave as DONE.
REQ-018 SHALL accept a new pipelined transfer in DONE, ERR2 or IDLE; with no new transfer it returns to IDLE.
REQ-019 SHALL hold HREADYout=0 in WDATA, SETUP, ACCESS and ERR1.
REQ-020 SHALL give these latencies, with acceptance at edge T and PREADY=1 on first ACCESS:
- read: SETUP T+1, ACCESS T+2, HREADYout/HRDATA valid T+3;
- write: one cycle later.
REQ-021 SHALL assert at most one PSEL bit at any time; PSEL is all-zero outside SETUP and ACCESS.
REQ-022 SHALL treat address and decode arithmetic as unsigned ADDR_W-bit values; BASE + window SHALL NOT wrap (wrapping is a parameter error).

Reset
REQ-023 SHALL, on any edge with HRESETn=0 and from any state including mid-ACCESS, enter IDLE and set HREADYout=1, HRESP=00, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0 and HRDATA=0; no APB transfer completes.

Configuration
REQ-024 SHALL, with APB_TIMEOUT_EN defined, count ACCESS cycles with PREADY=0; on reaching TIMEOUT_CYC it drops PSEL/PENABLE and goes to ERR1.
REQ-025 SHALL, with APB_TIMEOUT_EN undefined, wait indefinitely in ACCESS and contain no counter logic.

Structure
REQ-026 SHALL take the HTRANS and HRESP encodings and the state enum from shared package ahb_apb_pkg.
REQ-027 SHALL place address decode in the combinational sub-module ahb_apb_decode (inputs HADDR; outputs hit and one-hot select).

Verification
REQ-028 SHALL cover a single read at 0x8000_1004 with PRDATA=32'hCAFE_0001 and PREADY=1: expect PSEL=3'b010, HRDATA=CAFE_0001 with HRESP=OKAY at T+3.
REQ-029 SHALL cover a write of 32'h1234_5678 to 0x8000_2000 with PREADY held 0 for 3 ACCESS cycles: expect PSEL=3'b100, PWDATA stable throughout, HREADYout=1 at T+7.
REQ-030 SHALL cover a read at 0x9000_0000: expect no PSEL, HRESP=01 for 2 cycles, HREADYout 0 then 1.
REQ-031 SHALL cover PSLVERR=1 with PREADY on a write to 0x8000_0000: expect a two-cycle ERROR response.
REQ-032 SHALL cover back-to-back NONSEQ reads to slaves 0 and 2, the second presented in DONE: expect the second SETUP exactly 1 cycle after DONE.
REQ-033 SHALL cover HRESETn=0 during ACCESS: expect all outputs at reset values on the next edge; with APB_TIMEOUT_EN, PREADY stuck at 0 gives ERROR after 16 ACCESS cycles.
